cevero_dvfs_ctrl: RTL

Parametrised closed-loop DVFS controller: it monitors timing-error flags from several sources over fixed observation windows and steps the operating voltage and frequency levels one at a time. Each change goes through a req/ack handshake to the regulator/clock unit, followed by a settle interval. It sits between the core's error detectors and the power-management unit. Successor to the single-source controller, adding multi-source error counting, configurable widths and limits, handshaked level changes, ack timeout and an enable/idle mode.

---
 rtl/cevero_dvfs_pkg.sv | 40 ++++
 rtl/cevero_dvfs_if.sv | 34 +++
 rtl/cevero_dvfs_err_counter.sv | 50 +++++
 rtl/cevero_dvfs_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cevero_dvfs_pkg.sv
// -----------------------------------------------------------------------------
// cevero_dvfs_pkg
// Shared types and helpers for the closed-loop DVFS controller.
//   state_e      : controller FSM states
//   action_e     : single-step level change chosen at window evaluation
//   clamp_level  : clamp a level code into [lo, hi]
//   floor_level  : raise a level code to at least lo
// -----------------------------------------------------------------------------
package cevero_dvfs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MONITOR,
        EVAL,
        APPLY,
        SETTLE
    } state_e;

    typedef enum logic [2:0] {
        NONE,
        INCV,
        DECV,
        INCF,
        DECF
    } action_e;

    function automatic int unsigned clamp_level(input int unsigned lvl,
                                                input int unsigned lo,
                                                input int unsigned hi);
        if (lvl < lo) return lo;
        if (lvl > hi) return hi;
        return lvl;
    endfunction

    function automatic int unsigned floor_level(input int unsigned lvl,
                                                input int unsigned lo);
        return (lvl < lo) ? lo : lvl;
    endfunction

endpackage

// File: rtl/cevero_dvfs_if.sv
// -----------------------------------------------------------------------------
// cevero_dvfs_if
// Level-change handshake between the DVFS controller and the regulator/clock
// unit.
//   req_o         : level-change request (controller -> regulator)
//   tgt_voltage_o : requested voltage level, valid with req_o
//   tgt_freq_o    : requested frequency level, valid with req_o
//   ack_i         : regulator acknowledge (regulator -> controller)
// Modports: master = controller side, slave = regulator side.
// -----------------------------------------------------------------------------
interface cevero_dvfs_if #(
    parameter int unsigned LevelW = 3
) ();

    logic              req_o;
    logic [LevelW-1:0] tgt_voltage_o;
    logic [LevelW-1:0] tgt_freq_o;
    logic              ack_i;

    modport master (
        output req_o,
        output tgt_voltage_o,
        output tgt_freq_o,
        input  ack_i
    );

    modport slave (
        input  req_o,
        input  tgt_voltage_o,
        input  tgt_freq_o,
        output ack_i
    );

endinterface

// File: rtl/cevero_dvfs_err_counter.sv
// -----------------------------------------------------------------------------
// cevero_dvfs_err_counter
// Counts set error flags per cycle into a saturating window counter.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   clr_i   : clear the count (dominates)
//   sup_i   : hold the count, ignoring error_i
//   error_i : per-source error flags, each set bit adds one
//   cnt_o   : registered window error count
// -----------------------------------------------------------------------------
module cevero_dvfs_err_counter #(
    parameter int unsigned NumErrSrc = 2,
    parameter int unsigned CntW      = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 sup_i,
    input  logic [NumErrSrc-1:0] error_i,
    output logic [CntW-1:0]      cnt_o
);

    localparam int unsigned PcW  = $clog2(NumErrSrc + 1);
    localparam int unsigned SumW = CntW + 1;

    logic [PcW-1:0]  pop;
    logic [SumW-1:0] sum;

    // Population count of this cycle's error flags
    always_comb begin
        pop = '0;
        for (int i = 0; i < NumErrSrc; i++) begin
            pop = pop + PcW'(error_i[i]);
        end
    end

    // One spare bit catches overflow for saturation
    assign sum = {1'b0, cnt_o} + SumW'(pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (!sup_i) begin
            cnt_o <= sum[CntW] ? '1 : sum[CntW-1:0];
        end
    end

endmodule

// File: rtl/cevero_dvfs_ctrl.sv
// -----------------------------------------------------------------------------
// cevero_dvfs_ctrl
// Closed-loop DVFS controller. Counts timing errors over fixed windows and
// steps voltage or frequency by one level per decision, handshaking each change
// with the regulator and then waiting out a settle interval.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   en_i             : controller enable; low parks the controller in IDLE
//   error_i          : per-source timing-error flags
//   def_voltage_i    : default voltage level, loaded while idle
//   def_freq_i       : default (and highest requested) frequency level
//   set_voltage_o    : current voltage level
//   set_freq_o       : current frequency level
//   busy_o           : high while a change is requested or settling
//   fault_o          : sticky acknowledge-timeout flag
//   reg_if (master)  : req/tgt/ack handshake to the regulator
// -----------------------------------------------------------------------------
module cevero_dvfs_ctrl
    import cevero_dvfs_pkg::*;
#(
    parameter int unsigned LevelW       = 3,
    parameter int unsigned NumErrSrc    = 2,
    parameter int unsigned WindowCycles = 16,
    parameter int unsigned MaxErrors    = 3,
    parameter int unsigned OkWindows    = 10,
    parameter int unsigned MinVoltage   = 0,
    parameter int unsigned MaxVoltage   = 7,
    parameter int unsigned MinFreq      = 0,
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned AckTimeout   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [NumErrSrc-1:0] error_i,
    input  logic [LevelW-1:0]    def_voltage_i,
    input  logic [LevelW-1:0]    def_freq_i,
    output logic [LevelW-1:0]    set_voltage_o,
    output logic [LevelW-1:0]    set_freq_o,
    output logic                 busy_o,
    output logic                 fault_o,
    cevero_dvfs_if.master        reg_if
);

    localparam int unsigned CntW = $clog2(WindowCycles * NumErrSrc + 1);
    localparam int unsigned WinW = $clog2(WindowCycles);
    localparam int unsigned OkW  = $clog2(OkWindows + 1);
    localparam int unsigned SetW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam int unsigned AckW = $clog2(AckTimeout + 1);

    state_e            state;
    logic [CntW-1:0]   err_cnt;
    logic [WinW-1:0]   win_cnt;
    logic [OkW-1:0]    ok_cnt;
    logic [SetW-1:0]   settle_cnt;
    logic [AckW-1:0]   ack_cnt;
    logic              req_q;
    logic [LevelW-1:0] tgt_voltage_q;
    logic [LevelW-1:0] tgt_freq_q;

    action_e           act;
    logic [OkW-1:0]    ok_d;
    logic [LevelW-1:0] tgt_voltage_d;
    logic [LevelW-1:0] tgt_freq_d;

    assign reg_if.req_o         = req_q;
    assign reg_if.tgt_voltage_o = tgt_voltage_q;
    assign reg_if.tgt_freq_o    = tgt_freq_q;

    // Errors count only in MONITOR; the count is dropped after each evaluation
    cevero_dvfs_err_counter #(
        .NumErrSrc (NumErrSrc),
        .CntW      (CntW)
    ) u_err_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   ((state == IDLE) || (state == EVAL)),
        .sup_i   (state != MONITOR),
        .error_i (error_i),
        .cnt_o   (err_cnt)
    );

    // Window decision: safety first, then performance recovery, then energy
    always_comb begin
        act  = NONE;
        ok_d = '0;
        if (err_cnt > CntW'(MaxErrors)) begin
            if (set_voltage_o < LevelW'(MaxVoltage)) begin
                act = INCV;
            end else if (set_freq_o > LevelW'(MinFreq)) begin
                act = DECF;
            end
        end else if (err_cnt == '0) begin
            ok_d = ok_cnt + OkW'(1);
            if (ok_d == OkW'(OkWindows)) begin
                ok_d = '0;
                if (set_freq_o < def_freq_i) begin
                    act = INCF;
                end else if (set_voltage_o > LevelW'(MinVoltage)) begin
                    act = DECV;
                end
            end
        end
    end

    // Target levels: exactly one of the two moves by one step
    always_comb begin
        tgt_voltage_d = set_voltage_o;
        tgt_freq_d    = set_freq_o;
        case (act)
            INCV:    tgt_voltage_d = set_voltage_o + LevelW'(1);
            DECV:    tgt_voltage_d = set_voltage_o - LevelW'(1);
            INCF:    tgt_freq_d    = set_freq_o + LevelW'(1);
            DECF:    tgt_freq_d    = set_freq_o - LevelW'(1);
            default: ;
        endcase
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            set_voltage_o <= LevelW'(MaxVoltage);
            set_freq_o    <= LevelW'(MinFreq);
            req_q         <= 1'b0;
            tgt_voltage_q <= '0;
            tgt_freq_q    <= '0;
            busy_o        <= 1'b0;
            fault_o       <= 1'b0;
            win_cnt       <= '0;
            ok_cnt        <= '0;
            settle_cnt    <= '0;
            ack_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    set_voltage_o <= LevelW'(clamp_level(32'(def_voltage_i), MinVoltage, MaxVoltage));
                    set_freq_o    <= LevelW'(floor_level(32'(def_freq_i), MinFreq));
                    win_cnt       <= '0;
                    ok_cnt        <= '0;
                    settle_cnt    <= '0;
                    ack_cnt       <= '0;
                    if (en_i) state <= MONITOR;
                end
                MONITOR: begin
                    if (!en_i) begin
                        state <= IDLE;
                    end else if (win_cnt == WinW'(WindowCycles - 1)) begin
                        win_cnt <= '0;
                        state   <= EVAL;
                    end else begin
                        win_cnt <= win_cnt + WinW'(1);
                    end
                end
                EVAL: begin
                    if (!en_i) begin
                        state <= IDLE;
                    end else begin
                        ok_cnt <= ok_d;
                        if (act != NONE) begin
                            tgt_voltage_q <= tgt_voltage_d;
                            tgt_freq_q    <= tgt_freq_d;
                            req_q         <= 1'b1;
                            busy_o        <= 1'b1;
                            ack_cnt       <= '0;
                            state         <= APPLY;
                        end else begin
                            state <= MONITOR;
                        end
                    end
                end
                APPLY: begin
                    // Handshake finishes even if en_i drops; ack beats timeout
                    if (reg_if.ack_i) begin
                        set_voltage_o <= tgt_voltage_q;
                        set_freq_o    <= tgt_freq_q;
                        req_q         <= 1'b0;
                        settle_cnt    <= '0;
                        state         <= SETTLE;
                    end else if (ack_cnt == AckW'(AckTimeout - 1)) begin
                        req_q   <= 1'b0;
                        busy_o  <= 1'b0;
                        fault_o <= 1'b1;
                        state   <= en_i ? MONITOR : IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + AckW'(1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SetW'(SettleCycles - 1)) begin
                        settle_cnt <= '0;
                        busy_o     <= 1'b0;
                        state      <= en_i ? MONITOR : IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + SetW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
